muldiv_sequencer: RTL and testbench

Multi-cycle RV32M multiply/divide unit for the EX stage, alongside the single-cycle ALU. It accepts one operation per START pulse and runs an iterative 32-step shift-add multiply or restoring divide. It signals completion with a one-cycle DONE. BUSY drives the pipeline stall logic, so the hazard unit holds IF/ID/EX while an M-extension op is in flight.

---
 rtl/muldiv_pkg.sv | 25 ++
 rtl/muldiv_datapath.sv | 136 +++++++++++++
 rtl/muldiv_sequencer.sv | 107 ++++++++++
 tb/tb_muldiv_sequencer.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M multiply/divide sequencer.
// Contents: funct3 opcodes, FSM state encoding and iteration counter sizing.
package muldiv_pkg;

    // RV32M funct3 encodings
    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    // Iteration counter: 32 steps, 0..31
    localparam int unsigned CNT_W = 5;
    localparam logic [CNT_W-1:0] CNT_LAST = 5'd31;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/muldiv_datapath.sv
// Operand/accumulator registers and one-iteration arithmetic for the
// multiply/divide sequencer.
// Ports:
//   clk_i, rst_i     clock, async active-high reset
//   load_i           capture operands/op on accept (writes result for special cases)
//   step_i           run one shift-add / restore-subtract iteration
//   finish_i         last iteration: apply sign fix and register the result
//   funct3_i         RV32M op select
//   data1_i, data2_i rs1 / rs2 operands
//   special_c_o      combinational: current inputs are a divide special case
//   result_o         result register
module muldiv_datapath
    import muldiv_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            load_i,
    input  logic            step_i,
    input  logic            finish_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] data1_i,
    input  logic [XLEN-1:0] data2_i,
    output logic            special_c_o,
    output logic [XLEN-1:0] result_o
);

    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    logic [2:0]      f3_q;
    logic            neg_p_q;   // negate product / quotient
    logic            neg_r_q;   // negate remainder (dividend sign)
    logic [XLEN-1:0] b_q;       // multiplicand or divisor magnitude
    logic [XLEN-1:0] hi_q;      // product high / partial remainder
    logic [XLEN-1:0] lo_q;      // multiplier bits / quotient bits
    logic [XLEN-1:0] result_q;

    // Operand decode at accept time
    logic            div_op, sgn_a, sgn_b, a_neg, b_neg, spec_zero, spec_ovf;
    logic [XLEN-1:0] a_mag, b_mag, spec_res;

    always_comb begin
        div_op    = funct3_i[2];
        sgn_a     = (funct3_i != F3_MULHU) && (funct3_i != F3_DIVU) && (funct3_i != F3_REMU);
        sgn_b     = (funct3_i == F3_MUL) || (funct3_i == F3_MULH) ||
                    (funct3_i == F3_DIV) || (funct3_i == F3_REM);
        a_neg     = sgn_a && data1_i[XLEN-1];
        b_neg     = sgn_b && data2_i[XLEN-1];
        a_mag     = a_neg ? XLEN'(-data1_i) : data1_i;
        b_mag     = b_neg ? XLEN'(-data2_i) : data2_i;
        spec_zero = div_op && (data2_i == '0);
        spec_ovf  = div_op && sgn_b && (data1_i == INT_MIN) && (data2_i == '1);
        spec_res  = '0;
        if (spec_zero) begin
            spec_res = funct3_i[1] ? data1_i : '1;
        end else begin
            spec_res = funct3_i[1] ? '0 : INT_MIN;
        end
    end

    assign special_c_o = spec_zero || spec_ovf;

    // One iteration: shift-add multiply or restoring divide
    logic [XLEN:0]   sum, rem_sh, trial;
    logic [XLEN-1:0] hi_nx, lo_nx;

    always_comb begin
        sum    = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
        rem_sh = {hi_q, lo_q[XLEN-1]};
        trial  = rem_sh - {1'b0, b_q};
        hi_nx  = hi_q;
        lo_nx  = lo_q;
        if (f3_q[2]) begin
            // trial[XLEN] set means the subtraction went negative: restore
            if (!trial[XLEN]) begin
                hi_nx = trial[XLEN-1:0];
                lo_nx = {lo_q[XLEN-2:0], 1'b1};
            end else begin
                hi_nx = rem_sh[XLEN-1:0];
                lo_nx = {lo_q[XLEN-2:0], 1'b0};
            end
        end else begin
            hi_nx = sum[XLEN:1];
            lo_nx = {sum[0], lo_q[XLEN-1:1]};
        end
    end

    // Sign fix on the value produced by the final iteration
    logic [2*XLEN-1:0] prod, prod_s;
    logic [XLEN-1:0]   quo_s, rem_s, fin_res;

    always_comb begin
        prod   = {hi_nx, lo_nx};
        prod_s = neg_p_q ? (2*XLEN)'(-prod) : prod;
        quo_s  = neg_p_q ? XLEN'(-lo_nx) : lo_nx;
        rem_s  = neg_r_q ? XLEN'(-hi_nx) : hi_nx;
        if (f3_q[2]) begin
            fin_res = f3_q[1] ? rem_s : quo_s;
        end else begin
            fin_res = (f3_q == F3_MUL) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
        end
    end

    // Divide loads the dividend into lo; multiply loads the multiplier into lo
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            f3_q     <= '0;
            neg_p_q  <= 1'b0;
            neg_r_q  <= 1'b0;
            b_q      <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            result_q <= '0;
        end else if (load_i) begin
            f3_q    <= funct3_i;
            neg_p_q <= a_neg ^ b_neg;
            neg_r_q <= a_neg;
            b_q     <= div_op ? b_mag : a_mag;
            hi_q    <= '0;
            lo_q    <= div_op ? a_mag : b_mag;
            if (special_c_o) begin
                result_q <= spec_res;
            end
        end else if (step_i) begin
            hi_q <= hi_nx;
            lo_q <= lo_nx;
            if (finish_i) begin
                result_q <= fin_res;
            end
        end
    end

    assign result_o = result_q;

endmodule

// File: rtl/muldiv_sequencer.sv
// RV32M iterative multiply/divide unit: FSM, iteration counter and handshake.
// Ports:
//   CLK, RESET  clock, async active-high reset
//   START       op request, taken in IDLE or DONE
//   FUNCT3      RV32M op select
//   DATA1/DATA2 rs1 / rs2 operands, captured on accept
//   FLUSH       abort any in-flight op, wins over START
//   BUSY        high while iterating (stall request)
//   DONE        one-cycle completion pulse
//   RESULT      last completed result
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            START,
    input  logic [2:0]      FUNCT3,
    input  logic [XLEN-1:0] DATA1,
    input  logic [XLEN-1:0] DATA2,
    input  logic            FLUSH,
    output logic            BUSY,
    output logic            DONE,
    output logic [XLEN-1:0] RESULT
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             load_c, step_c, finish_c, special_c;

    // State register plus registered status outputs
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next state, counter and datapath controls
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        load_c   = 1'b0;
        step_c   = 1'b0;
        finish_c = 1'b0;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        if (FLUSH) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                ST_CALC: begin
                    step_c = 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        finish_c = 1'b1;
                        state_d  = ST_DONE;
                        cnt_d    = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    // IDLE and DONE both accept a new op
                    if (START) begin
                        load_c  = 1'b1;
                        cnt_d   = '0;
                        state_d = special_c ? ST_DONE : ST_CALC;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            endcase
        end
        busy_d = (state_d == ST_CALC);
        done_d = (state_d == ST_DONE);
    end

    muldiv_datapath #(
        .XLEN(XLEN)
    ) u_datapath (
        .clk_i       (CLK),
        .rst_i       (RESET),
        .load_i      (load_c),
        .step_i      (step_c),
        .finish_i    (finish_c),
        .funct3_i    (FUNCT3),
        .data1_i     (DATA1),
        .data2_i     (DATA2),
        .special_c_o (special_c),
        .result_o    (RESULT)
    );

    assign BUSY = busy_q;
    assign DONE = done_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed RV32M ops with
// hand-computed results, plus a per-cycle latency/arithmetic reference model.
module tb_muldiv_sequencer;

    logic        CLK = 1'b0;
    logic        RESET, START, FLUSH;
    logic [2:0]  FUNCT3;
    logic [31:0] DATA1, DATA2;
    logic        BUSY, DONE;
    logic [31:0] RESULT;

    int checks   = 0;
    int failures = 0;

    muldiv_sequencer #(.XLEN(32)) dut (
        .CLK    (CLK),
        .RESET  (RESET),
        .START  (START),
        .FUNCT3 (FUNCT3),
        .DATA1  (DATA1),
        .DATA2  (DATA2),
        .FLUSH  (FLUSH),
        .BUSY   (BUSY),
        .DONE   (DONE),
        .RESULT (RESULT)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural result of an RV32M op, from plain 64-bit arithmetic
    function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb, ua, ub, p;
        longint unsigned up;
        logic [63:0]     r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'h0, a});
        ub = longint'({32'h0, b});
        r  = '0;
        case (f)
            3'd0: begin p = sa * sb; r = p; return r[31:0]; end
            3'd1: begin p = sa * sb; r = p; return r[63:32]; end
            3'd2: begin p = sa * ub; r = p; return r[63:32]; end
            3'd3: begin up = longint'(ua) * longint'(ub); r = up; return r[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                p = sa / sb; r = p; return r[31:0];
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                return a / b;
            end
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                p = sa % sb; r = p; return r[31:0];
            end
            default: begin
                if (b == 0) return a;
                return a % b;
            end
        endcase
    endfunction

    function automatic bit ref_special(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        return f[2] && ((b == 0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    endfunction

    // Reference: an accepted op is either immediate (special) or busy for 32 cycles
    logic        m_busy, m_done;
    logic [31:0] m_res, m_pend;
    int          m_left;

    always @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_res  <= '0;
            m_pend <= '0;
            m_left <= 0;
        end else if (FLUSH) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_left <= 0;
        end else if (m_busy) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_busy <= 1'b0;
                m_done <= 1'b1;
                m_res  <= m_pend;
            end
        end else if (START) begin
            if (ref_special(FUNCT3, DATA1, DATA2)) begin
                m_done <= 1'b1;
                m_res  <= ref_op(FUNCT3, DATA1, DATA2);
            end else begin
                m_busy <= 1'b1;
                m_done <= 1'b0;
                m_left <= 32;
                m_pend <= ref_op(FUNCT3, DATA1, DATA2);
            end
        end else begin
            m_done <= 1'b0;
        end
    end

    // Per-cycle comparison against the reference
    always @(negedge CLK) begin
        check("cyc_busy", 32'(BUSY), 32'(m_busy));
        check("cyc_done", 32'(DONE), 32'(m_done));
        check("cyc_result", RESULT, m_res);
    end

    // Issue one op and wait (bounded) for DONE; b2b issues in the current DONE cycle.
    // poke_at > 0 raises a stray START with other operands at that cycle of the op.
    task automatic run_op(input string name, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat,
                          input bit b2b, input int poke_at);
        int lat, busy_n;
        if (!b2b) begin
            @(posedge CLK); #1;
        end
        START = 1'b1; FUNCT3 = f; DATA1 = a; DATA2 = b;
        @(posedge CLK); #1;
        START = 1'b0;
        lat = 1; busy_n = 0;
        while (!DONE && lat < 40) begin
            if (BUSY) busy_n++;
            if (lat == poke_at) begin
                START = 1'b1; FUNCT3 = 3'b000; DATA1 = 32'd3; DATA2 = 32'd4;
            end else begin
                START = 1'b0;
            end
            @(posedge CLK); #1;
            lat++;
        end
        START = 1'b0;
        check({name, "_latency"}, 32'(lat), 32'(exp_lat));
        check({name, "_busy_cycles"}, 32'(busy_n), (exp_lat == 33) ? 32'd32 : 32'd0);
        check({name, "_result"}, RESULT, exp_res);
    endtask

    // Pin the reference model to hand values
    task automatic pin_model();
        check("model_mul",   ref_op(3'd0, 32'd7, 32'hFFFF_FFFD), 32'hFFFF_FFEB);
        check("model_mulhu", ref_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFE);
        check("model_rem",   ref_op(3'd6, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFF);
        check("model_divov", ref_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF), 32'h8000_0000);
    endtask

    initial begin
        int dn;
        logic [31:0] held;
        RESET = 1'b1; START = 1'b0; FLUSH = 1'b0;
        FUNCT3 = '0; DATA1 = '0; DATA2 = '0;
        pin_model();
        repeat (2) @(posedge CLK);
        #1;
        check("reset_busy", 32'(BUSY), 32'd0);
        check("reset_done", 32'(DONE), 32'd0);
        check("reset_result", RESULT, 32'd0);
        RESET = 1'b0;

        // Multiply
        run_op("mul_7x-3",     3'b000, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, 0, 0);
        @(posedge CLK); #1;
        check("mul_done_one_cycle", 32'(DONE), 32'd0);
        run_op("mulhu_m1xm1",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, 0, 0);
        run_op("mulh_m1xm1",   3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33, 0, 0);
        run_op("mulhsu_m1x2",  3'b010, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 33, 0, 0);

        // Divide
        run_op("div_m7_2",     3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, 0, 0);
        run_op("rem_m7_2",     3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, 0, 0);
        run_op("divu_100_7",   3'b101, 32'd100,       32'd7, 32'd14,        33, 0, 0);
        run_op("remu_100_7",   3'b111, 32'd100,       32'd7, 32'd2,         33, 0, 0);

        // Special cases
        run_op("divu_5_0",     3'b101, 32'd5,         32'd0,         32'hFFFF_FFFF, 1, 0, 0);
        run_op("remu_5_0",     3'b111, 32'd5,         32'd0,         32'd5,         1, 0, 0);
        run_op("div_ovf",      3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0, 0);
        run_op("rem_ovf",      3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1, 0, 0);
        run_op("rem_m5_0",     3'b110, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 1, 0, 0);

        // Flush at CALC cycle 10
        held = 32'hFFFF_FFFB;
        @(posedge CLK); #1;
        START = 1'b1; FUNCT3 = 3'b000; DATA1 = 32'h1234_5678; DATA2 = 32'd9;
        @(posedge CLK); #1;
        START = 1'b0;
        repeat (9) begin @(posedge CLK); #1; end
        FLUSH = 1'b1;
        @(posedge CLK); #1;
        FLUSH = 1'b0;
        check("flush_busy_low", 32'(BUSY), 32'd0);
        dn = 0;
        repeat (40) begin
            if (DONE) dn++;
            @(posedge CLK); #1;
        end
        check("flush_no_done", 32'(dn), 32'd0);
        check("flush_result_held", RESULT, held);
        run_op("mul_3x4_after_flush", 3'b000, 32'd3, 32'd4, 32'd12, 33, 0, 0);

        // START during CALC ignored
        run_op("divu_start_in_calc", 3'b101, 32'd100, 32'd7, 32'd14, 33, 0, 5);

        // Back-to-back: second op issued in the DONE cycle of the first
        run_op("remu_b2b_first",  3'b111, 32'd100, 32'd7, 32'd2, 33, 0, 0);
        run_op("mulhu_b2b_second", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, 1, 0);
        run_op("divu_b2b_special", 3'b101, 32'd9, 32'd0, 32'hFFFF_FFFF, 1, 1, 0);

        // Async reset mid-CALC
        @(posedge CLK); #1;
        START = 1'b1; FUNCT3 = 3'b000; DATA1 = 32'd7; DATA2 = 32'd6;
        @(posedge CLK); #1;
        START = 1'b0;
        repeat (5) begin @(posedge CLK); #1; end
        #1 RESET = 1'b1;
        #1;
        check("midreset_busy", 32'(BUSY), 32'd0);
        check("midreset_done", 32'(DONE), 32'd0);
        check("midreset_result", RESULT, 32'd0);
        @(posedge CLK); #1;
        RESET = 1'b0;
        dn = 0;
        repeat (40) begin
            if (DONE || BUSY) dn++;
            @(posedge CLK); #1;
        end
        check("midreset_quiet", 32'(dn), 32'd0);
        run_op("mul_3x4_after_reset", 3'b000, 32'd3, 32'd4, 32'd12, 33, 0, 0);

        repeat (3) @(posedge CLK);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
